// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RISC-V M-extension sequencer that sits beside the execute-stage ALU.
// Multiply uses radix-2 shift-add and divide uses restoring division, one bit per cycle over XLEN cycles.
// Divide-by-zero and signed overflow complete without iterating.
// Optional macro MULDIV_EARLY_OUT_EN: when defined, zero multiplies and divides with |a| < |b|
// also complete without iterating.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   start       M-op in EXE with operands valid; sampled only in IDLE
//   funct3      M-op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   op_a, op_b  forwarded rs1 and rs2 values
//   flush       aborts an op in BUSY/FIX; blocks a start in IDLE
//   stall_req   freezes IF/ID/EXE while the op is running
//   busy        state != IDLE
//   done        one-cycle result-valid strobe
//   result      final value; holds until the next write
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_q, state_d;
    logic [2:0]          f3_q, f3_d;
    logic                sa_q, sa_d, sb_q, sb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    // Multiply: {hi, lo} product with the multiplier in lo.
    // Divide: {rem, quot} with the dividend in quot.
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [XLEN-1:0]     res_q, res_d;

    // Operand conditioning at start
    logic            is_div, sgn_a_op, sgn_b_op, sa_in, sb_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            special;
    logic [XLEN-1:0] special_val;

    always_comb begin
        is_div   = funct3[2];
        sgn_a_op = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn_b_op = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sa_in    = sgn_a_op & op_a[XLEN-1];
        sb_in    = sgn_b_op & op_b[XLEN-1];
        a_mag    = sa_in ? -op_a : op_a;
        b_mag    = sb_in ? -op_b : op_b;
        special     = 1'b0;
        special_val = '0;
        if (is_div && op_b == '0) begin
            special     = 1'b1;
            special_val = funct3[1] ? op_a : '1;
        end else if (is_div && !funct3[0] && op_a == MOST_NEG && op_b == '1) begin
            special     = 1'b1;
            special_val = funct3[1] ? '0 : op_a;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if (!is_div && (op_a == '0 || op_b == '0)) begin
            special     = 1'b1;
            special_val = '0;
        end else if (is_div && a_mag < b_mag) begin
            // Quotient is zero; the remainder is the dividend with its own sign.
            special     = 1'b1;
            special_val = funct3[1] ? op_a : '0;
        end
`endif
    end

    // One iteration of each algorithm
    logic [XLEN:0]     msum, dsh, ddiff;
    logic              dge;
    logic [2*XLEN-1:0] mul_next, div_next;

    always_comb begin
        msum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {msum, acc_q[XLEN-1:1]};
        dsh      = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        dge      = dsh >= {1'b0, opb_q};
        ddiff    = dsh - {1'b0, opb_q};
        div_next = {(dge ? ddiff[XLEN-1:0] : dsh[XLEN-1:0]), acc_q[XLEN-2:0], dge};
    end

    // Sign correction and result selection
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, fix_val;

    always_comb begin
        prod_s = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quot_s = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_s  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (f3_q)
            3'b000:         fix_val = prod_s[XLEN-1:0];
            3'b100, 3'b101: fix_val = quot_s;
            3'b110, 3'b111: fix_val = rem_s;
            default:        fix_val = prod_s[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    f3_d  = funct3;
                    sa_d  = sa_in;
                    sb_d  = sb_in;
                    cnt_d = '0;
                    acc_d = {{XLEN{1'b0}}, a_mag};
                    opb_d = b_mag;
                    if (special) begin
                        res_d   = special_val;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = f3_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    res_d   = fix_val;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            f3_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
        end
    end

    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign stall_req = (state_q == S_IDLE && start && !flush) || state_q == S_BUSY || state_q == S_FIX;
    assign result    = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (XLEN=32).
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        stall_req, busy, done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO_LAT = 0;
`else
    localparam int EO_LAT = 33;
`endif

    muldiv_seq #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .stall_req(stall_req), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issues one op and checks latency (edges after the start edge), stall behaviour and result.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        bit stall_ok;
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        #1;
        check({tag, "_stall_start"}, 64'(stall_req), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        stall_ok = 1'b1;
        while (!done && n < 100) begin
            if (!stall_req) stall_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_stall_run"}, 64'(stall_ok), 64'd1);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_stall_done"}, 64'(stall_req), 64'd0);
        check({tag, "_result"}, 64'(result), 64'(exp));
        @(posedge clk); #1;
        check({tag, "_done_drop"}, 64'(done), 64'd0);
        check({tag, "_result_hold"}, 64'(result), 64'(exp));
    endtask

    initial begin
        logic [31:0] prev;
        int n;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_stall", 64'(stall_req), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mul_7_m3",   3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_op("mulhu_ff",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("mulh_ff",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        run_op("mulhsu_ff",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        run_op("div_m20_3",  3'b100, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 33);
        run_op("rem_m20_3",  3'b110, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 33);
        run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
        run_op("div_by0",    3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 0);
        run_op("remu_by0",   3'b111, 32'd5, 32'd0, 32'd5, 0);
        run_op("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        run_op("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);

        // Flush during iteration 10 of a DIVU.
        prev = result;
        funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_result", 64'(result), 64'(prev));
        n = 0;
        repeat (2) begin @(posedge clk); #1; if (done) n++; end
        check("flush_no_done", 64'(n), 64'd0);
        run_op("divu_after_flush", 3'b101, 32'd1000, 32'd3, 32'd333, 33);

        // Asynchronous reset mid-operation.
        funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mul_0_x",    3'b000, 32'd0, 32'd12345, 32'd0, EO_LAT);
        run_op("divu_3_10",  3'b101, 32'd3, 32'd10, 32'd0, EO_LAT);
        run_op("remu_3_10",  3'b111, 32'd3, 32'd10, 32'd3, EO_LAT);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
